counter_sequencer: RTL

- Controller that sequences an up/down counter (enable + countDirection interface) under a programmable tick rate.
- Issues single-cycle step enables from an internal prescaler and chooses direction per mode: continuous up, continuous down, ping-pong between limits, or single up-sweep to a limit.
- Reads the counter value back and sits between board-level controls (buttons/switches) and the counter instance.

---
 rtl/counter_seq_pkg.sv | 18 +
 rtl/counter_sequencer_tick_prescaler.sv | 26 ++
 rtl/counter_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared mode, state and direction encodings for the counter sequencer.
package counter_seq_pkg;
    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_SWEEP    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// tick_prescaler: free-running interval counter; one-cycle tick when it reaches max(period,1).
module tick_prescaler #(
    parameter int PRESCALE_BITS = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     run,
    input  logic [PRESCALE_BITS-1:0] period,
    output logic                     tick
);
    logic [PRESCALE_BITS-1:0] cnt;
    logic [PRESCALE_BITS-1:0] lim;

    // A zero period would tick every cycle; clamping keeps steps at least two cycles apart.
    assign lim  = (period == '0) ? PRESCALE_BITS'(1) : period;
    assign tick = run && (cnt == lim);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: drives an up/down counter's enable/direction per mode at a programmable tick rate.
// Optional pause input enabled by defining COUNTER_SEQ_PAUSE_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int COUNTER_SIZE  = 4,
    parameter int PRESCALE_BITS = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
`ifdef COUNTER_SEQ_PAUSE_EN
    input  logic                     pause,
`endif
    input  logic [1:0]               mode,
    input  logic [PRESCALE_BITS-1:0] period,
    input  logic [COUNTER_SIZE-1:0]  low_limit,
    input  logic [COUNTER_SIZE-1:0]  high_limit,
    input  logic [COUNTER_SIZE-1:0]  count_value,
    output logic                     count_enable,
    output logic                     count_direction,
    output logic                     busy,
    output logic                     done
);
    state_t                    state, state_nxt;
    mode_t                     mode_q;
    logic [PRESCALE_BITS-1:0]  period_q;
    logic [COUNTER_SIZE-1:0]   low_q, high_q;
    logic                      accept, run, tick;
    logic                      en_nxt, dir_nxt, done_nxt;

    // A ping-pong range with no room between limits is rejected outright.
    assign accept = (state == IDLE) && start && !stop &&
                    !((mode == MODE_PINGPONG) && (high_limit <= low_limit));

`ifdef COUNTER_SEQ_PAUSE_EN
    assign run = (state != IDLE) && !pause;
`else
    assign run = state != IDLE;
`endif

    tick_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .run    (run),
        .period (period_q),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        dir_nxt   = count_direction;
        done_nxt  = 1'b0;
        if (stop)
            state_nxt = IDLE;
        else if (state == IDLE) begin
            if (accept) begin
                state_nxt = (mode == MODE_DOWN) ? RUN_DOWN : RUN_UP;
                dir_nxt   = (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
            end
        end else if (tick) begin
            en_nxt = 1'b1;
            if (mode_q == MODE_PINGPONG && state == RUN_UP && count_value >= high_q) begin
                state_nxt = RUN_DOWN;
                dir_nxt   = DIR_DOWN;
            end else if (mode_q == MODE_PINGPONG && state == RUN_DOWN && count_value <= low_q) begin
                state_nxt = RUN_UP;
                dir_nxt   = DIR_UP;
            end else if (mode_q == MODE_SWEEP && count_value == high_q) begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= IDLE;
            count_enable    <= 1'b0;
            count_direction <= DIR_UP;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nxt;
            count_enable    <= en_nxt;
            count_direction <= dir_nxt;
            busy            <= state_nxt != IDLE;
            done            <= done_nxt;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mode_q   <= MODE_UP;
            period_q <= '0;
            low_q    <= '0;
            high_q   <= '0;
        end else if (accept) begin
            mode_q   <= mode_t'(mode);
            period_q <= period;
            low_q    <= low_limit;
            high_q   <= high_limit;
        end
endmodule
